// File: rtl/cdiff_evt_queue_pkg.sv
// Types shared by the L1 update event queue: cache field types, the queued event
// record and the coalescing merge used when a push lands on the tail entry.
package cdiff_evt_queue_pkg;

    localparam int L1_SET_W = 6;
    localparam int L1_WAY_W = 2;
    localparam int PADDR_W  = 40;
    localparam int CL_W     = 512;

    typedef logic [L1_SET_W-1:0] t_l1_set_addr;
    typedef logic [L1_WAY_W-1:0] t_l1_way;
    typedef logic [PADDR_W-1:0]  t_paddr;
    typedef logic [CL_W-1:0]     t_cl;

    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} t_mesi;
    typedef enum logic [1:0] {ARB_LD, ARB_ST, ARB_SNP, ARB_FILL} t_mempipe_arb_type;

    typedef struct packed {
        logic              tag_wr;
        logic              state_wr;
        logic              data_wr;
        t_l1_set_addr      set;
        t_l1_way           way;
        t_paddr            paddr;
        t_mesi             mesi;
        t_cl               data;
        t_mempipe_arb_type arb_type;
    } t_cdiff_evt;

    // Later write wins only for the arrays it actually touched.
    function automatic t_cdiff_evt f_cdiff_evt_merge(t_cdiff_evt o, t_cdiff_evt n);
        t_cdiff_evt m;
        m          = o;
        m.tag_wr   = o.tag_wr   | n.tag_wr;
        m.state_wr = o.state_wr | n.state_wr;
        m.data_wr  = o.data_wr  | n.data_wr;
        if (n.tag_wr)   m.paddr = n.paddr;
        if (n.state_wr) m.mesi  = n.mesi;
        if (n.data_wr)  m.data  = n.data;
        m.arb_type = n.arb_type;
        return m;
    endfunction

endpackage

// File: rtl/cdiff_evt_queue_if.sv
// Event capture and drain handshake for the L1 update event queue.
interface cdiff_evt_queue_if;
    import cdiff_evt_queue_pkg::*;

    logic              evt_vld_mm4;
    logic              evt_tag_wr;
    logic              evt_state_wr;
    logic              evt_data_wr;
    t_l1_set_addr      evt_set;
    t_l1_way           evt_way;
    t_paddr            evt_paddr;
    t_mesi             evt_mesi;
    t_cl               evt_data;
    t_mempipe_arb_type evt_arb_type;
    logic              out_vld;
    logic              out_rdy;
    t_cdiff_evt        out_evt;

    modport master (
        output evt_vld_mm4, evt_tag_wr, evt_state_wr, evt_data_wr, evt_set, evt_way,
               evt_paddr, evt_mesi, evt_data, evt_arb_type, out_rdy,
        input  out_vld, out_evt
    );

    modport slave (
        input  evt_vld_mm4, evt_tag_wr, evt_state_wr, evt_data_wr, evt_set, evt_way,
               evt_paddr, evt_mesi, evt_data, evt_arb_type, out_rdy,
        output out_vld, out_evt
    );

endinterface

// File: rtl/cdiff_evt_queue.sv
// Coalescing show-ahead FIFO of L1 MM4 array-update events with saturating drop count.
module cdiff_evt_queue
    import cdiff_evt_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16,
    parameter int COALESCE = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    cdiff_evt_queue_if.slave         evt_if,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [CNT_W-1:0]         o_drop_cnt,
    output logic                     o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    t_cdiff_evt       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    t_cdiff_evt       w_new;
    logic [PTR_W-1:0] w_tail_ptr;
    logic             w_push;
    logic             w_pop;
    logic             w_tail_hit;
    logic             w_merge;
    logic             w_alloc;
    logic             w_drop;

    always_comb begin
        w_new.tag_wr   = evt_if.evt_tag_wr;
        w_new.state_wr = evt_if.evt_state_wr;
        w_new.data_wr  = evt_if.evt_data_wr;
        w_new.set      = evt_if.evt_set;
        w_new.way      = evt_if.evt_way;
        w_new.paddr    = evt_if.evt_paddr;
        w_new.mesi     = evt_if.evt_mesi;
        w_new.data     = evt_if.evt_data;
        w_new.arb_type = evt_if.evt_arb_type;
    end

    assign w_tail_ptr = r_wr_ptr - PTR_W'(1);
    assign w_push     = evt_if.evt_vld_mm4 &
                        (evt_if.evt_tag_wr | evt_if.evt_state_wr | evt_if.evt_data_wr);
    assign w_pop      = (r_count != '0) & evt_if.out_rdy;
    assign w_tail_hit = (r_mem[w_tail_ptr].set == evt_if.evt_set) &&
                        (r_mem[w_tail_ptr].way == evt_if.evt_way);

    // A tail leaving this cycle cannot absorb the push; it would vanish with the pop.
    assign w_merge = (COALESCE != 0) && w_push && !i_flush && (r_count != '0) &&
                     w_tail_hit && !((r_count == CW'(1)) && w_pop);
    assign w_alloc = w_push && !i_flush && !w_merge &&
                     ((r_count < CW'(DEPTH)) || w_pop);
    assign w_drop  = w_push && !i_flush && !w_merge && !w_alloc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_alloc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_merge)
            r_mem[w_tail_ptr] <= f_cdiff_evt_merge(r_mem[w_tail_ptr], w_new);
        else if (w_alloc)
            r_mem[r_wr_ptr] <= w_new;
    end

    assign evt_if.out_vld = (r_count != '0);
    assign evt_if.out_evt = r_mem[r_rd_ptr];
    assign o_count        = r_count;
    assign o_drop_cnt     = r_drop_cnt;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_cdiff_evt_queue.sv
// Directed scoreboard bench for cdiff_evt_queue: stimulus queues expected head
// events, a negedge monitor compares each accepted head against the queue.
module tb_cdiff_evt_queue;
    import cdiff_evt_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  count;
    logic [15:0] drop_cnt;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    t_cdiff_evt exp_q[$];

    cdiff_evt_queue_if ifc ();

    cdiff_evt_queue #(.DEPTH(8), .CNT_W(16), .COALESCE(1)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_flush    (flush),
        .evt_if     (ifc),
        .o_count    (count),
        .o_drop_cnt (drop_cnt),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic t_cdiff_evt mk(input logic tw, input logic sw, input logic dw,
                                      input int set, input int way, input logic [39:0] pa,
                                      input t_mesi m, input logic [511:0] d,
                                      input t_mempipe_arb_type a);
        t_cdiff_evt e;
        e.tag_wr = tw; e.state_wr = sw; e.data_wr = dw;
        e.set = 6'(set); e.way = 2'(way); e.paddr = pa;
        e.mesi = m; e.data = d; e.arb_type = a;
        return e;
    endfunction

    // Monitor: a head accepted this cycle must match the scoreboard front.
    always @(negedge clk) begin
        if (!rst && ifc.out_vld && ifc.out_rdy) begin
            t_cdiff_evt e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got set=%0d way=%0d, required nothing",
                         ifc.out_evt.set, ifc.out_evt.way);
            end else begin
                e = exp_q.pop_front();
                if (ifc.out_evt !== e) begin
                    errors++;
                    $display("FAIL sb_evt: got set=%0d way=%0d f=%b%b%b pa=%h m=%0d arb=%0d d=%h data_eq=%0d, required set=%0d way=%0d f=%b%b%b pa=%h m=%0d arb=%0d d=%h",
                             ifc.out_evt.set, ifc.out_evt.way, ifc.out_evt.tag_wr,
                             ifc.out_evt.state_wr, ifc.out_evt.data_wr, ifc.out_evt.paddr,
                             ifc.out_evt.mesi, ifc.out_evt.arb_type, ifc.out_evt.data[31:0],
                             ifc.out_evt.data == e.data, e.set, e.way, e.tag_wr, e.state_wr,
                             e.data_wr, e.paddr, e.mesi, e.arb_type, e.data[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input t_cdiff_evt e);
        ifc.evt_vld_mm4  = 1'b1;
        ifc.evt_tag_wr   = e.tag_wr;
        ifc.evt_state_wr = e.state_wr;
        ifc.evt_data_wr  = e.data_wr;
        ifc.evt_set      = e.set;
        ifc.evt_way      = e.way;
        ifc.evt_paddr    = e.paddr;
        ifc.evt_mesi     = e.mesi;
        ifc.evt_data     = e.data;
        ifc.evt_arb_type = e.arb_type;
        tick();
        ifc.evt_vld_mm4  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        ifc.out_rdy = 1'b1;
        while (count != 0 && n < 40) begin
            tick();
            n++;
        end
        ifc.out_rdy = 1'b0;
        chk({name, "_count"}, 64'(count), 64'd0);
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t_cdiff_evt e, a, b;
        ifc.evt_vld_mm4 = 0; ifc.evt_tag_wr = 0; ifc.evt_state_wr = 0; ifc.evt_data_wr = 0;
        ifc.evt_set = '0; ifc.evt_way = '0; ifc.evt_paddr = '0; ifc.evt_mesi = MESI_I;
        ifc.evt_data = '0; ifc.evt_arb_type = ARB_LD; ifc.out_rdy = 0;
        flush = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_vld", 64'(ifc.out_vld), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // 1: three back-to-back pushes drained at full rate
        ifc.out_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            e = mk(1, 1, 0, i, 0, 40'h100 * i, MESI_S, {16{32'(i)}}, ARB_LD);
            exp_q.push_back(e);
            push(e);
            if (i == 1) begin
                chk("t1_latency_vld", 64'(ifc.out_vld), 64'd1);
                chk("t1_count1", 64'(count), 64'd1);
            end
        end
        tick();
        chk("t1_count_empty", 64'(count), 64'd0);
        ifc.out_rdy = 1'b0;

        // 2: coalesce state write then data write on the same set/way
        a = mk(0, 1, 0, 5, 1, 40'hAA_0000_0040, MESI_E, {16{32'h1111_2222}}, ARB_LD);
        b = mk(0, 0, 1, 5, 1, 40'hBB_0000_0080, MESI_M, {64{8'hAB}}, ARB_ST);
        push(a);
        push(b);
        e = mk(0, 1, 1, 5, 1, 40'hAA_0000_0040, MESI_E, {64{8'hAB}}, ARB_ST);
        chk("t2_count", 64'(count), 64'd1);
        chk("t2_head_flags", 64'({ifc.out_evt.state_wr, ifc.out_evt.data_wr}), 64'b11);
        chk("t2_head_mesi", 64'(ifc.out_evt.mesi), 64'(MESI_E));
        chk("t2_head_data_ab", 64'(ifc.out_evt.data == {64{8'hAB}}), 64'd1);
        exp_q.push_back(e);
        drain("t2");

        // 3: overflow a stalled queue with ten distinct events
        for (int i = 0; i < 10; i++) begin
            e = mk(1, 0, 0, 10 + i, i % 4, 40'h1000 * i, MESI_S, {16{32'(i)}}, ARB_LD);
            if (i < 8) exp_q.push_back(e);
            push(e);
        end
        chk("t3_count_full", 64'(count), 64'd8);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        chk("t3_overflow", 64'(overflow), 64'd1);
        drain("t3");

        // 4: push into a full queue while the head pops
        for (int i = 0; i < 8; i++) begin
            e = mk(0, 0, 1, 30 + i, 2, 40'h2000, MESI_M, {16{32'(100 + i)}}, ARB_FILL);
            exp_q.push_back(e);
            push(e);
        end
        chk("t4_count_full", 64'(count), 64'd8);
        ifc.out_rdy = 1'b1;
        e = mk(1, 1, 1, 40, 3, 40'h3000, MESI_E, {16{32'hCAFE}}, ARB_SNP);
        exp_q.push_back(e);
        push(e);
        ifc.out_rdy = 1'b0;
        chk("t4_count_stay", 64'(count), 64'd8);
        chk("t4_drop_same", 64'(drop_cnt), 64'd2);
        drain("t4");

        // 5: matching push while the only entry pops must not merge
        a = mk(0, 1, 0, 4, 0, 40'h4000, MESI_S, {16{32'h4444}}, ARB_LD);
        b = mk(0, 0, 1, 4, 0, 40'h5000, MESI_M, {16{32'h5555}}, ARB_ST);
        exp_q.push_back(a);
        push(a);
        ifc.out_rdy = 1'b1;
        exp_q.push_back(b);
        push(b);
        ifc.out_rdy = 1'b0;
        chk("t5_count", 64'(count), 64'd1);
        chk("t5_head_new", 64'(ifc.out_evt === b), 64'd1);
        drain("t5");

        // 6: flush with simultaneous push, then reset mid-drain
        for (int i = 0; i < 5; i++) begin
            e = mk(1, 0, 0, 50 + i, 0, 40'h6000, MESI_S, {16{32'(i)}}, ARB_LD);
            exp_q.push_back(e);
            push(e);
        end
        chk("t6_count5", 64'(count), 64'd5);
        flush = 1'b1;
        push(mk(1, 0, 0, 60, 1, 40'h7000, MESI_S, '0, ARB_LD));
        flush = 1'b0;
        exp_q.delete();
        chk("t6_flush_count", 64'(count), 64'd0);
        chk("t6_flush_vld", 64'(ifc.out_vld), 64'd0);
        chk("t6_flush_drop", 64'(drop_cnt), 64'd2);
        chk("t6_flush_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            e = mk(0, 1, 0, 20 + i, 1, 40'h8000, MESI_E, {16{32'(i)}}, ARB_ST);
            exp_q.push_back(e);
            push(e);
        end
        ifc.out_rdy = 1'b1;
        tick();
        ifc.out_rdy = 1'b0;
        chk("t6_sb_one_popped", 64'(exp_q.size()), 64'd2);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_vld", 64'(ifc.out_vld), 64'd0);
        chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
        chk("t6_rst_ovf", 64'(overflow), 64'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
